mem_arbiter: RTL and testbench

Single-port memory arbiter between the core's three MMU-side channels (instruction read, data read, data write) and one request/acknowledge memory bus. It captures the core's per-cycle requests, serialises them by fixed priority onto the bus, and returns read results. It generates `MEM_WAIT`, which freezes the core pipeline while any captured request is outstanding.

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Single-port memory arbiter. It captures the core's per-cycle instruction-read,
// data-read and data-write requests and serialises them onto one
// request/acknowledge bus. Priority is write > data read > instruction read.
// Read results go back to the core, and MEM_WAIT stalls the core pipeline while
// any captured request is still outstanding.
//
// Ports:
//   CLK, RST                 clock; synchronous active-low reset
//   INST_RDEN/RIADDR         instruction read request and address
//   INST_ROADDR/RVALID/RDATA instruction read result
//   DATA_RDEN/RIADDR         data read request and address
//   DATA_ROADDR/RVALID/RDATA data read result
//   DATA_WREN/WADDR/WDATA    full-word data write request
//   MEM_WAIT                 pipeline hold
//   MEM_REQ/WE/ADDR/WDATA    bus request fields, registered and held until ack
//   MEM_ACK/RDATA            bus completion; read data valid with ack
module mem_arbiter #(
    parameter int unsigned WORD_ALIGN = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {CH_W, CH_D, CH_I} chan_t;

    state_t      state_q, state_d;
    chan_t       sel_q, sel_d;
    logic        pw_q, pw_d, pd_q, pd_d, pi_q, pi_d;
    logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
    logic [31:0] daddr_q, daddr_d, iaddr_q, iaddr_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        inst_rvalid_q, inst_rvalid_d, data_rvalid_q, data_rvalid_d;
    logic [31:0] inst_roaddr_q, inst_roaddr_d, inst_rdata_q, inst_rdata_d;
    logic [31:0] data_roaddr_q, data_roaddr_d, data_rdata_q, data_rdata_d;
    logic        mem_wait;

    // Built only from registers, so there is no input-to-output path.
    assign mem_wait = pw_q | pd_q | pi_q | (state_q == BUSY);

    function automatic logic [31:0] bus_addr(input logic [31:0] a);
        return (WORD_ALIGN != 0) ? {a[31:2], 2'b00} : a;
    endfunction

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pw_d          = pw_q;
        pd_d          = pd_q;
        pi_d          = pi_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        daddr_d       = daddr_q;
        iaddr_d       = iaddr_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        inst_rvalid_d = inst_rvalid_q;
        inst_roaddr_d = inst_roaddr_q;
        inst_rdata_d  = inst_rdata_q;
        data_rvalid_d = data_rvalid_q;
        data_roaddr_d = data_roaddr_q;
        data_rdata_d  = data_rdata_q;

        if (!mem_wait) begin
            // A result is shown for exactly one unstalled cycle, then dropped.
            inst_rvalid_d = 1'b0;
            data_rvalid_d = 1'b0;
            if (DATA_WREN) begin
                pw_d    = 1'b1;
                waddr_d = DATA_WADDR;
                wdata_d = DATA_WDATA;
            end
            if (DATA_RDEN) begin
                pd_d    = 1'b1;
                daddr_d = DATA_RIADDR;
            end
            if (INST_RDEN) begin
                pi_d    = 1'b1;
                iaddr_d = INST_RIADDR;
            end
        end

        case (state_q)
            IDLE: begin
                // MEM_ACK is deliberately ignored here.
                if (pw_q) begin
                    state_d     = BUSY;
                    sel_d       = CH_W;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus_addr(waddr_q);
                    mem_wdata_d = wdata_q;
                end else if (pd_q) begin
                    state_d    = BUSY;
                    sel_d      = CH_D;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus_addr(daddr_q);
                end else if (pi_q) begin
                    state_d    = BUSY;
                    sel_d      = CH_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus_addr(iaddr_q);
                end
            end
            BUSY: begin
                if (MEM_ACK) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    case (sel_q)
                        CH_W: pw_d = 1'b0;
                        CH_D: begin
                            pd_d          = 1'b0;
                            data_rvalid_d = 1'b1;
                            data_roaddr_d = daddr_q;
                            data_rdata_d  = MEM_RDATA;
                        end
                        default: begin
                            pi_d          = 1'b0;
                            inst_rvalid_d = 1'b1;
                            inst_roaddr_d = iaddr_q;
                            inst_rdata_d  = MEM_RDATA;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= IDLE;
            sel_q         <= CH_W;
            pw_q          <= 1'b0;
            pd_q          <= 1'b0;
            pi_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            daddr_q       <= '0;
            iaddr_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            inst_rvalid_q <= 1'b0;
            inst_roaddr_q <= '0;
            inst_rdata_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_roaddr_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            pw_q          <= pw_d;
            pd_q          <= pd_d;
            pi_q          <= pi_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            daddr_q       <= daddr_d;
            iaddr_q       <= iaddr_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_roaddr_q <= inst_roaddr_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rvalid_q <= data_rvalid_d;
            data_roaddr_q <= data_roaddr_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign MEM_WAIT    = mem_wait;
    assign MEM_REQ     = mem_req_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WDATA   = mem_wdata_q;
    assign INST_RVALID = inst_rvalid_q;
    assign INST_ROADDR = inst_roaddr_q;
    assign INST_RDATA  = inst_rdata_q;
    assign DATA_RVALID = data_rvalid_q;
    assign DATA_ROADDR = data_roaddr_q;
    assign DATA_RDATA  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter. Each operation is turned into an ordered
// list of bus transactions by priority, with a chosen latency for each one. The
// expected cycle timeline is then derived from that list, and a word-addressed
// memory model supplies the read data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        RST;
    logic        INST_RDEN, DATA_RDEN, DATA_WREN;
    logic [31:0] INST_RIADDR, DATA_RIADDR, DATA_WADDR, DATA_WDATA;
    logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA;
    logic        INST_RVALID, DATA_RVALID;
    logic        MEM_WAIT, MEM_REQ, MEM_WE, MEM_ACK;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_ALIGN(1)) dut (
        .CLK(clk), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
        .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
        .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
        .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned ch;   // 0 write, 1 data read, 2 inst read
    } txn_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] mem_model [logic [31:0]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Random core-side activity while stalled; it must never be captured.
    task automatic scramble_inputs();
        DATA_WREN   = 1'($urandom_range(1, 0));
        DATA_RDEN   = 1'($urandom_range(1, 0));
        INST_RDEN   = 1'($urandom_range(1, 0));
        DATA_WADDR  = $urandom;
        DATA_WDATA  = $urandom;
        DATA_RIADDR = $urandom;
        INST_RIADDR = $urandom;
    endtask

    task automatic clear_inputs();
        DATA_WREN = 1'b0;
        DATA_RDEN = 1'b0;
        INST_RDEN = 1'b0;
    endtask

    // Called just after a negedge, with MEM_WAIT expected low.
    task automatic run_op(input bit w, input bit d, input bit i,
                          input logic [31:0] wa, input logic [31:0] wd,
                          input logic [31:0] da, input logic [31:0] ia,
                          input int unsigned lat_min, input int unsigned lat_max);
        txn_t        q[$];
        bit          vi = 1'b0, vd = 1'b0;
        logic [31:0] ri = '0, rd = '0;
        int unsigned lat;
        DATA_WREN = w; DATA_WADDR = wa; DATA_WDATA = wd;
        DATA_RDEN = d; DATA_RIADDR = da;
        INST_RDEN = i; INST_RIADDR = ia;
        MEM_ACK = 1'b0;
        @(negedge clk);
        if (!(w || d || i)) begin
            check_val("wait_no_req", 32'(MEM_WAIT), 32'd0);
            return;
        end
        check_val("wait_capture", 32'(MEM_WAIT), 32'd1);
        check_val("req_capture", 32'(MEM_REQ), 32'd0);
        if (w) q.push_back('{we: 1'b1, addr: wa, wdata: wd, ch: 0});
        if (d) q.push_back('{we: 1'b0, addr: da, wdata: '0, ch: 1});
        if (i) q.push_back('{we: 1'b0, addr: ia, wdata: '0, ch: 2});
        scramble_inputs();
        for (int j = 0; j < q.size(); j++) begin
            lat = $urandom_range(lat_max, lat_min);
            for (int unsigned c = 0; c < lat; c++) begin
                @(negedge clk);
                check_val("req_busy", 32'(MEM_REQ), 32'd1);
                check_val("we_busy", 32'(MEM_WE), 32'(q[j].we));
                check_val("addr_busy", MEM_ADDR, word_of(q[j].addr));
                if (q[j].we) check_val("wdata_busy", MEM_WDATA, q[j].wdata);
                check_val("wait_busy", 32'(MEM_WAIT), 32'd1);
                check_val("ivalid_busy", 32'(INST_RVALID), 32'(vi));
                check_val("dvalid_busy", 32'(DATA_RVALID), 32'(vd));
                scramble_inputs();
                if (c == lat - 1) begin
                    MEM_ACK = 1'b1;
                    if (q[j].we) begin
                        MEM_RDATA = $urandom;
                        mem_model[word_of(q[j].addr)] = q[j].wdata;
                    end else begin
                        MEM_RDATA = mem_word(word_of(q[j].addr));
                        if (q[j].ch == 1) begin vd = 1'b1; rd = MEM_RDATA; end
                        else begin vi = 1'b1; ri = MEM_RDATA; end
                    end
                end else begin
                    MEM_ACK   = 1'b0;
                    MEM_RDATA = $urandom;
                end
            end
            @(negedge clk);
            MEM_ACK = 1'b0;
            check_val("req_after_ack", 32'(MEM_REQ), 32'd0);
            check_val("ivalid_gap", 32'(INST_RVALID), 32'(vi));
            check_val("dvalid_gap", 32'(DATA_RVALID), 32'(vd));
            if (j < q.size() - 1) begin
                check_val("wait_gap", 32'(MEM_WAIT), 32'd1);
                scramble_inputs();
                MEM_ACK = 1'($urandom_range(1, 0));   // ack while idle is ignored
            end else begin
                check_val("wait_done", 32'(MEM_WAIT), 32'd0);
                clear_inputs();
            end
        end
        if (vi) begin
            check_val("iroaddr", INST_ROADDR, ia);
            check_val("irdata", INST_RDATA, ri);
        end
        if (vd) begin
            check_val("droaddr", DATA_ROADDR, da);
            check_val("drdata", DATA_RDATA, rd);
        end
        @(negedge clk);
        check_val("ivalid_drop", 32'(INST_RVALID), 32'd0);
        check_val("dvalid_drop", 32'(DATA_RVALID), 32'd0);
        check_val("wait_idle", 32'(MEM_WAIT), 32'd0);
        check_val("req_idle", 32'(MEM_REQ), 32'd0);
        if (vi) check_val("irdata_keep", INST_RDATA, ri);
        if (vd) check_val("drdata_keep", DATA_RDATA, rd);
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        RST = 1'b0;
        MEM_ACK = 1'b0;
        MEM_RDATA = '0;
        DATA_WREN = 1'b1; DATA_WADDR = 32'h40; DATA_WDATA = 32'hDEADBEEF;
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h40;
        INST_RDEN = 1'b1; INST_RIADDR = 32'h8;

        // Reset held with every enable high.
        repeat (3) begin
            @(negedge clk);
            check_val("rst_req", 32'(MEM_REQ), 32'd0);
            check_val("rst_wait", 32'(MEM_WAIT), 32'd0);
            check_val("rst_addr", MEM_ADDR, 32'd0);
            check_val("rst_ivalid", 32'(INST_RVALID), 32'd0);
            check_val("rst_dvalid", 32'(DATA_RVALID), 32'd0);
            check_val("rst_drdata", DATA_RDATA, 32'd0);
        end

        // Release: capture on the very next edge; three-way contention, 1-cycle bus.
        RST = 1'b1;
        run_op(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h40, 32'h8, 1, 1);
        check_val("rdata_write_first", DATA_RDATA, 32'hDEADBEEF);

        // Single instruction fetch, then an unaligned fetch of the same word.
        mem_model[32'h100] = 32'h0000_0013;
        run_op(1'b0, 1'b0, 1'b1, '0, '0, '0, 32'h100, 1, 1);
        check_val("fetch_data", INST_RDATA, 32'h13);
        run_op(1'b0, 1'b0, 1'b1, '0, '0, '0, 32'h103, 1, 2);
        check_val("align_roaddr", INST_ROADDR, 32'h103);

        // Slow bus: five-cycle ack.
        run_op(1'b0, 1'b1, 1'b0, '0, '0, 32'h100, '0, 5, 5);
        check_val("slow_data", DATA_RDATA, 32'h13);

        // Randomised mix on a small address pool so reads often hit earlier writes.
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(15, 0) << 4) | $urandom_range(3, 0);
            rb = ($urandom_range(15, 0) << 4) | $urandom_range(3, 0);
            rc = ($urandom_range(15, 0) << 4) | $urandom_range(3, 0);
            if (n % 4 == 0) rb = ra;
            run_op(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   ra, $urandom, rb, rc, 1, 4);
        end

        // Reset mid-transaction; the late ack must be ignored.
        INST_RDEN = 1'b1; INST_RIADDR = 32'h200;
        @(negedge clk);
        check_val("mid_wait", 32'(MEM_WAIT), 32'd1);
        INST_RDEN = 1'b0;
        @(negedge clk);
        check_val("mid_req", 32'(MEM_REQ), 32'd1);
        RST = 1'b0;
        @(negedge clk);
        check_val("mid_rst_req", 32'(MEM_REQ), 32'd0);
        check_val("mid_rst_wait", 32'(MEM_WAIT), 32'd0);
        check_val("mid_rst_iaddr", INST_ROADDR, 32'd0);
        RST = 1'b1;
        @(negedge clk);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            MEM_ACK = 1'b0;
            check_val("late_ack_req", 32'(MEM_REQ), 32'd0);
            check_val("late_ack_wait", 32'(MEM_WAIT), 32'd0);
            check_val("late_ack_ivalid", 32'(INST_RVALID), 32'd0);
            check_val("late_ack_irdata", INST_RDATA, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
